// File: rtl/axi2apb_sched.sv
// axi2apb_sched: command scheduler for the AXI-to-APB bridge.
//
// Arbitrates between AXI AW and AR address requests (round-robin by default),
// then expands the accepted burst into single-beat APB commands. One beat is
// issued at a time and the next one is held until the downstream controller
// pulses `finish`. Only one burst is outstanding at any time.
//
// Optional feature macro: AXI2APB_SCHED_WPRIO_EN
//   defined   - writes have strict priority; a read waiting through 4
//               consecutive write grants is then forced through.
//   undefined - round-robin between AW and AR.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   AW* / AR*                 AXI write / read address channels
//   cmd_valid / cmd_ready     beat command handshake
//   cmd_read, cmd_id,
//   cmd_addr, cmd_last,
//   cmd_err                   beat command payload ({slave[3:0], offset} address)
//   finish                    one-cycle pulse: issued beat fully completed
//   busy                      a burst is in progress
module axi2apb_sched #(
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned APB_NUM_SLAVES = 8,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ID_WIDTH-1:0]   AWID,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [AXI_ID_WIDTH-1:0]   ARID,
    input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic [2:0]                ARSIZE,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic                      cmd_read,
    output logic [AXI_ID_WIDTH-1:0]   cmd_id,
    output logic [APB_ADDR_WIDTH+3:0] cmd_addr,
    output logic                      cmd_last,
    output logic                      cmd_err,
    input  logic                      finish,
    output logic                      busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                    state_q, state_d;
    logic                      grant_w, grant_r, accept;
    logic [AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [2:0]                sel_size;
    logic [3:0]                sel_slave;
    logic                      sel_err;
    logic [APB_ADDR_WIDTH-1:0] incr;

    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [3:0]                slave_q;
    logic [APB_ADDR_WIDTH-1:0] off_q;
    logic [7:0]                beats_q;
    logic [2:0]                size_q;
    logic                      read_q;
    logic                      err_q;

    // Upper AXI address bits select nothing on APB.
    logic unused_addr_bits;
    assign unused_addr_bits = ^sel_addr[AXI_ADDR_WIDTH-1:APB_ADDR_WIDTH+4];

`ifdef AXI2APB_SCHED_WPRIO_EN
    logic [2:0] starve_q;

    // Writes win unless the pending read has sat through 4 write grants.
    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (ARVALID && (!AWVALID || starve_q == 3'd4)) begin
                grant_r = 1'b1;
            end else if (AWVALID) begin
                grant_w = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 3'd0;
        end else if (grant_r) begin
            starve_q <= 3'd0;
        end else if (grant_w) begin
            starve_q <= ARVALID ? starve_q + 3'd1 : 3'd0;
        end
    end
`else
    logic last_read_q;  // 1: last grant went to the read channel

    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (AWVALID && ARVALID) begin
                grant_w = last_read_q;
                grant_r = ~last_read_q;
            end else begin
                grant_w = AWVALID;
                grant_r = ARVALID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_read_q <= 1'b1;
        end else if (accept) begin
            last_read_q <= grant_r;
        end
    end
`endif

    assign accept  = grant_w | grant_r;
    assign AWREADY = grant_w;
    assign ARREADY = grant_r;

    assign sel_addr  = grant_r ? ARADDR : AWADDR;
    assign sel_size  = grant_r ? ARSIZE : AWSIZE;
    assign sel_slave = sel_addr[APB_ADDR_WIDTH +: 4];
    assign sel_err   = (sel_size > 3'd2) || ({1'b0, sel_slave} >= 5'(APB_NUM_SLAVES));

    // Only the offset advances; the slave index is held, so the offset wraps.
    assign incr = {{(APB_ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (accept) state_d = StIssue;
            end
            StIssue: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_d = StWait;
            end
            StWait: begin
                if (finish) state_d = (beats_q == 8'd0) ? StIdle : StIssue;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            slave_q <= 4'd0;
            off_q   <= '0;
            beats_q <= 8'd0;
            size_q  <= 3'd0;
            read_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            id_q    <= grant_r ? ARID : AWID;
            slave_q <= sel_slave;
            off_q   <= sel_addr[APB_ADDR_WIDTH-1:0];
            beats_q <= grant_r ? ARLEN : AWLEN;
            size_q  <= sel_size;
            read_q  <= grant_r;
            err_q   <= sel_err;
        end else if (state_q == StWait && finish && beats_q != 8'd0) begin
            off_q   <= off_q + incr;
            beats_q <= beats_q - 8'd1;
        end
    end

    assign cmd_read = read_q;
    assign cmd_id   = id_q;
    assign cmd_addr = {slave_q, off_q};
    assign cmd_err  = err_q;
    assign cmd_last = (state_q != StIdle) && (beats_q == 8'd0);

endmodule

// File: tb/tb_axi2apb_sched.sv
module tb_axi2apb_sched;
    localparam int IDW = 6;
    localparam int AW  = 32;
    localparam int PAW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [IDW-1:0]  AWID, ARID;
    logic [AW-1:0]   AWADDR, ARADDR;
    logic [7:0]      AWLEN, ARLEN;
    logic [2:0]      AWSIZE, ARSIZE;
    logic            AWVALID, ARVALID, AWREADY, ARREADY;
    logic            cmd_valid, cmd_ready, cmd_read, cmd_last, cmd_err;
    logic [IDW-1:0]  cmd_id;
    logic [PAW+3:0]  cmd_addr;
    logic            finish, busy;

    axi2apb_sched #(
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .APB_NUM_SLAVES(8), .APB_ADDR_WIDTH(PAW)
    ) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_last(cmd_last), .cmd_err(cmd_err),
        .finish(finish), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rd;
        logic [IDW-1:0] id;
        logic [31:0]    addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic           err;
    } vec_t;

    typedef struct {
        logic           rd;
        logic [IDW-1:0] id;
        logic [15:0]    addr;
        logic           last;
        logic           err;
    } beat_t;

    beat_t sb[$];
    int    compared   = 0;
    int    mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats: offset advances by 1<<size modulo 4096, slave nibble held.
    task automatic push_exp(input vec_t v);
        beat_t      b;
        logic [3:0]  slv;
        logic [11:0] off;
        slv = v.addr[15:12];
        off = v.addr[11:0];
        for (int i = 0; i <= int'(v.len); i++) begin
            b.rd   = v.rd;
            b.id   = v.id;
            b.addr = {slv, off};
            b.last = (i == int'(v.len));
            b.err  = v.err;
            sb.push_back(b);
            off = off + (12'd1 << v.size);
        end
    endtask

    task automatic send(input vec_t v);
        int to;
        @(posedge clk); #1;
        if (v.rd) begin
            ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARSIZE = v.size; ARVALID = 1'b1;
        end else begin
            AWID = v.id; AWADDR = v.addr; AWLEN = v.len; AWSIZE = v.size; AWVALID = 1'b1;
        end
        #1;
        to = 0;
        while (!(v.rd ? ARREADY : AWREADY) && to < 20) begin
            @(posedge clk); #2; to++;
        end
        chk("req_ready", 32'(v.rd ? ARREADY : AWREADY), 32'd1);
        chk("other_ready_low", 32'(v.rd ? AWREADY : ARREADY), 32'd0);
        push_exp(v);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        ARVALID = 1'b0;
        chk("accept_to_cmd_latency", 32'(cmd_valid), 32'd1);
    endtask

    // Pops and checks up to max_beats beats; the first beat is stalled `stall` cycles.
    task automatic serve(input int stall, input int max_beats, output int n);
        beat_t e;
        int    to;
        n = 0;
        while (sb.size() > 0 && n < max_beats) begin
            to = 0;
            while (!cmd_valid && to < 20) begin
                @(posedge clk); #1; to++;
            end
            if (!cmd_valid) begin
                chk("cmd_valid_timeout", 32'(cmd_valid), 32'd1);
                sb.delete();
                return;
            end
            e = sb.pop_front();
            for (int s = 0; s < ((n == 0) ? stall : 0); s++) begin
                finish = (s == 0);  // must be ignored outside WAIT
                @(posedge clk); #1;
                finish = 1'b0;
                chk("hold_valid", 32'(cmd_valid), 32'd1);
                chk("hold_addr", 32'(cmd_addr), 32'(e.addr));
            end
            chk("cmd_read", 32'(cmd_read), 32'(e.rd));
            chk("cmd_id", 32'(cmd_id), 32'(e.id));
            chk("cmd_addr", 32'(cmd_addr), 32'(e.addr));
            chk("cmd_last", 32'(cmd_last), 32'(e.last));
            chk("cmd_err", 32'(cmd_err), 32'(e.err));
            cmd_ready = 1'b1;
            @(posedge clk); #1;
            cmd_ready = 1'b0;
            chk("wait_valid_low", 32'(cmd_valid), 32'd0);
            @(posedge clk); #1;
            finish = 1'b1;
            @(posedge clk); #1;
            finish = 1'b0;
            n++;
            if (e.last) chk("busy_after_last", 32'(busy), 32'd0);
            else        chk("finish_to_next_valid", 32'(cmd_valid), 32'd1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];
    int   n;
    int   to;
    logic exp_grant[6];
    vec_t gw, gr, v;

    initial begin
        //            rd    id      addr           len     size  err
        vecs[0] = '{1'b0, 6'd5,  32'h0000_3010, 8'd0,   3'd2, 1'b0};
        vecs[1] = '{1'b1, 6'h2A, 32'h0000_1FF8, 8'd3,   3'd2, 1'b0};
        vecs[2] = '{1'b0, 6'd3,  32'h0000_2000, 8'd1,   3'd3, 1'b1};
        vecs[3] = '{1'b1, 6'd7,  32'h0000_9004, 8'd2,   3'd2, 1'b1};
        vecs[4] = '{1'b0, 6'h3F, 32'hABCD_7FFE, 8'd2,   3'd1, 1'b0};
        vecs[5] = '{1'b1, 6'd1,  32'h0000_8000, 8'd0,   3'd0, 1'b1};
        vecs[6] = '{1'b0, 6'd9,  32'h0000_0100, 8'd255, 3'd0, 1'b0};
`ifdef AXI2APB_SCHED_WPRIO_EN
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

        rst = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0;
        cmd_ready = 1'b0;
        finish = 1'b0;

        // Reset: no handshake may complete while rst is high.
        repeat (2) @(posedge clk);
        #1 AWVALID = 1'b1;
        #1 chk("awready_in_reset", 32'(AWREADY), 32'd0);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        rst = 1'b0;
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_last", 32'(cmd_last), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("rst_cmd_read", 32'(cmd_read), 32'd0);
        chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rst_cmd_id", 32'(cmd_id), 32'd0);

        // Table-driven bursts.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i]);
            serve((i == 1) ? 2 : 0, 1000, n);
            chk("beat_count", 32'(n), 32'(int'(vecs[i].len) + 1));
        end

        // Reset while waiting on beat 2 of 4.
        v = '{1'b1, 6'd9, 32'h0000_1FF8, 8'd3, 3'd2, 1'b0};
        send(v);
        serve(0, 1, n);
        chk("beat2_valid", 32'(cmd_valid), 32'd1);
        chk("beat2_addr", 32'(cmd_addr), 32'h1FFC);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        chk("beat2_in_wait", 32'(cmd_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("midrst_cmd_last", 32'(cmd_last), 32'd0);
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        chk("idle_finish_ignored", 32'(busy), 32'd0);

        // Both channels held valid: grant order, never both READYs.
        gw = '{1'b0, 6'd1, 32'h0000_1000, 8'd0, 3'd2, 1'b0};
        gr = '{1'b1, 6'd2, 32'h0000_2000, 8'd0, 3'd2, 1'b0};
        AWID = gw.id; AWADDR = gw.addr; AWLEN = gw.len; AWSIZE = gw.size; AWVALID = 1'b1;
        ARID = gr.id; ARADDR = gr.addr; ARLEN = gr.len; ARSIZE = gr.size; ARVALID = 1'b1;
        for (int g = 0; g < 6; g++) begin
            #1;
            to = 0;
            while (!(AWREADY || ARREADY) && to < 20) begin
                @(posedge clk); #2; to++;
            end
            chk("tie_some_ready", 32'(AWREADY | ARREADY), 32'd1);
            chk("tie_one_ready", 32'(AWREADY & ARREADY), 32'd0);
            chk("tie_grant_order", 32'(ARREADY), 32'(exp_grant[g]));
            push_exp(ARREADY ? gr : gw);
            @(posedge clk); #1;
            chk("ready_low_when_busy", 32'(AWREADY | ARREADY), 32'd0);
            serve(0, 1000, n);
        end
        AWVALID = 1'b0;
        ARVALID = 1'b0;

        // A lone read after the tie sequence.
        v = '{1'b1, 6'd4, 32'h0000_0040, 8'd1, 3'd2, 1'b0};
        send(v);
        serve(0, 1000, n);
        chk("final_beat_count", 32'(n), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/axi2apb_sched.md
Name: axi2apb_sched

Overview:
- Command scheduler in front of the APB sequencing logic of the AXI-to-APB bridge.
- Accepts AXI AW and AR address requests and arbitrates between them, round-robin by default.
- Expands each accepted burst into single-beat APB commands with per-beat address, ID, direction, last and error flags.
- Issues one beat at a time; holds the next beat until the downstream controller reports completion of the current one.

Parameters:
- AXI_ID_WIDTH, 6, width of AXI transaction IDs.
- AXI_ADDR_WIDTH, 32, width of AXI addresses.
- APB_NUM_SLAVES, 8, number of APB slaves; legal slave index range is 0..APB_NUM_SLAVES-1 (max 16).
- APB_ADDR_WIDTH, 12, per-slave APB address width; the slave index is taken from addr[APB_ADDR_WIDTH+3:APB_ADDR_WIDTH].

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- AWID  in  AXI_ID_WIDTH  write ID.
- AWADDR  in  AXI_ADDR_WIDTH  write start address.
- AWLEN  in  8  write beats minus 1.
- AWSIZE  in  3  write beat size, log2 bytes.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accepted.
- ARID  in  AXI_ID_WIDTH  read ID.
- ARADDR  in  AXI_ADDR_WIDTH  read start address.
- ARLEN  in  8  read beats minus 1.
- ARSIZE  in  3  read beat size.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accepted.
- cmd_valid  out  1  beat command valid.
- cmd_ready  in  1  downstream accepts the beat.
- cmd_read  out  1  1 = read beat, 0 = write beat.
- cmd_id  out  AXI_ID_WIDTH  ID of the current burst.
- cmd_addr  out  APB_ADDR_WIDTH+4  {slave index[3:0], APB offset}.
- cmd_last  out  1  current beat is the final beat of the burst.
- cmd_err  out  1  burst is illegal; the beat must be answered SLVERR without an APB access.
- finish  in  1  one-cycle pulse: the issued beat has completed on APB and on the AXI R/B side.
- busy  out  1  a burst is in progress (state != IDLE).

Behaviour:
- Reset: state IDLE; AWREADY, ARREADY, cmd_valid, cmd_read, cmd_last, cmd_err, busy all 0; cmd_id and cmd_addr 0; last_grant = read, so the first tie goes to write.
- States:
  - IDLE: arbitrate. If exactly one of AWVALID/ARVALID is high, grant it. If both, grant the channel opposite last_grant. The granted READY is asserted combinationally in the same cycle (READY depends on VALID, never the reverse); only one READY is high in any cycle. On acceptance, register ID, address, len, size, direction and the error flag; update last_grant; go to ISSUE next cycle.
  - ISSUE: cmd_valid=1 with stable outputs until cmd_ready. On cmd_valid&&cmd_ready go to WAIT.
  - WAIT: cmd_valid=0. On finish: if beats_left==0 go to IDLE, else decrement beats_left, add the increment to the address, go to ISSUE.
- A finish pulse in IDLE or ISSUE is ignored.
- Accept-to-first-cmd_valid latency: 1 cycle. Finish-to-next-cmd_valid latency: 1 cycle.
- No new AW/AR is accepted until the current burst completes; at most one burst is outstanding.
- Address arithmetic:
  - increment = 1<<size; only the APB offset bits advance, wrapping modulo 2^APB_ADDR_WIDTH; slave index bits are held.
  - Example, APB_ADDR_WIDTH=12: 0xFFC + 4 -> 0x000 of the same slave.
- cmd_last = (beats_left==0). beats_left loads len (0..255), so a 256-beat burst issues 256 beats.
- Error (cmd_err=1 for every beat of the burst) when either:
  - size > 2 (beat wider than 32 bits), or
  - slave index >= APB_NUM_SLAVES.
  - All len+1 beats are still issued, so the W data is drained and R/B responses match the burst length.
- Reset mid-burst: return to IDLE next cycle, all outputs to their reset values, the burst is discarded.

Optional Feature:
- AXI2APB_SCHED_WPRIO_EN.
- Defined: in IDLE, writes have strict priority over reads. A read is granted only when AWVALID=0, or when the read starvation counter reaches 4: the read has been waiting (ARVALID=1) through 4 consecutive write grants. That read is then granted and the counter is cleared. The counter also clears on any read grant and on reset.
- Undefined: round-robin as described in Behaviour; no counter is present.

Test Plan:
- Single write: AWADDR=0x0000_3010, AWLEN=0, AWSIZE=2 -> AWREADY 1 cycle; next cycle cmd_valid with cmd_read=0, cmd_addr=0x3010, cmd_last=1, cmd_err=0; finish -> IDLE, busy=0.
- Read burst: ARADDR=0x0000_1FF8, ARLEN=3, ARSIZE=2 -> cmd_addr sequence 0x1FF8, 0x1FFC, 0x1000, 0x1004 (wrap within slave 1); cmd_last only on the 4th beat; each beat held until cmd_ready; next beat 1 cycle after finish.
- Simultaneous AWVALID/ARVALID held for 4 bursts of AWLEN=ARLEN=0 -> grants W, R, W, R; never both READYs high in one cycle.
- Error cases -> cmd_err=1 on all beats and exactly len+1 beats issued:
  - AWSIZE=3, AWLEN=1 -> 2 beats.
  - Slave index 9 with APB_NUM_SLAVES=8 -> cmd_err=1 on every beat.
- rst pulse during WAIT of beat 2/4 -> next cycle IDLE, cmd_valid=0, busy=0; a later AR is accepted normally with the first tie going to write.
- AXI2APB_SCHED_WPRIO_EN defined, AWVALID and ARVALID held high continuously -> grants W, W, W, W, R, W, ...; feature undefined -> strict alternation.
